// File: rtl/game_timer_if.sv
// Control and display signals between the game FSM / HUD side and the level timer.
interface game_timer_if;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic       reload;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       count_tick;
    logic       warn;
    logic       time_up;

    modport master (
        output tick_in, start, pause, reload,
        input  bcd_hund, bcd_tens, bcd_ones, running, count_tick, warn, time_up
    );

    modport slave (
        input  tick_in, start, pause, reload,
        output bcd_hund, bcd_tens, bcd_ones, running, count_tick, warn, time_up
    );
endinterface

// File: rtl/game_timer.sv
// Level countdown timer: synchronises the divided tick, prescales it and
// decrements a 3-digit BCD count with hurry-up and time-up indications.
module game_timer #(
    parameter int unsigned START_VALUE    = 400,
    parameter int unsigned TICKS_PER_UNIT = 40,
    parameter int unsigned WARN_VALUE     = 100
) (
    input  logic         clk,
    input  logic         rst,
    game_timer_if.slave  bus
);
    localparam int unsigned PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);

    localparam logic [3:0] START_H = 4'((START_VALUE / 100) % 10);
    localparam logic [3:0] START_T = 4'((START_VALUE / 10) % 10);
    localparam logic [3:0] START_O = 4'(START_VALUE % 10);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic          s1_q, s2_q, s3_q;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic          count_tick_q, count_tick_d;
    logic          time_up_q, time_up_d;
    logic          warn_q, warn_d;

    logic          tick_pulse;
    logic          presc_wrap;
    logic          fire;
    logic          is_zero;
    logic          dec_zero;
    logic [3:0]    dec_h, dec_t, dec_o;
    logic [9:0]    count_bin;

    always_comb begin
        tick_pulse = s2_q & ~s3_q;
        presc_wrap = tick_pulse && (presc_q == PRESC_LAST);
        is_zero    = (hund_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

        // Borrow chain: ones wraps 0->9 into tens, tens wraps 0->9 into hundreds
        dec_h = hund_q;
        dec_t = tens_q;
        dec_o = ones_q - 4'd1;
        if (ones_q == 4'd0) begin
            dec_o = 4'd9;
            if (tens_q == 4'd0) begin
                dec_t = 4'd9;
                dec_h = hund_q - 4'd1;
            end else begin
                dec_t = tens_q - 4'd1;
            end
        end
        dec_zero = (dec_h == 4'd0) && (dec_t == 4'd0) && (dec_o == 4'd0);

        state_d      = state_q;
        presc_d      = presc_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        count_tick_d = 1'b0;
        time_up_d    = 1'b0;
        fire         = 1'b0;

        if (bus.reload) begin
            state_d = ST_IDLE;
            presc_d = '0;
            hund_d  = START_H;
            tens_d  = START_T;
            ones_d  = START_O;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.pause) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (tick_pulse)
                        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
                    fire = presc_wrap && !is_zero;
                    if (fire) begin
                        hund_d       = dec_h;
                        tens_d       = dec_t;
                        ones_d       = dec_o;
                        count_tick_d = 1'b1;
                    end
                    // Reaching 000 takes precedence over a coincident pause
                    if (fire && dec_zero) begin
                        state_d   = ST_EXPIRED;
                        time_up_d = 1'b1;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.start && !bus.pause)
                        state_d = ST_RUN;
                end
                ST_EXPIRED: ;
                default: state_d = ST_IDLE;
            endcase
        end

        count_bin = 10'(hund_q) * 10'd100 + 10'(tens_q) * 10'd10 + 10'(ones_q);
        warn_d    = (count_bin < 10'(WARN_VALUE)) && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            hund_q       <= START_H;
            tens_q       <= START_T;
            ones_q       <= START_O;
            count_tick_q <= 1'b0;
            time_up_q    <= 1'b0;
            warn_q       <= 1'b0;
        end else begin
            s1_q         <= bus.tick_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            state_q      <= state_d;
            presc_q      <= presc_d;
            hund_q       <= hund_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            count_tick_q <= count_tick_d;
            time_up_q    <= time_up_d;
            warn_q       <= warn_d;
        end
    end

    assign bus.bcd_hund   = hund_q;
    assign bus.bcd_tens   = tens_q;
    assign bus.bcd_ones   = ones_q;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.count_tick = count_tick_q;
    assign bus.time_up    = time_up_q;
    assign bus.warn       = warn_q;
endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: event-level countdown model driven by
// randomised square-wave ticks and control pulses.
module tb_game_timer;
    localparam int START = 12;
    localparam int TPU   = 3;
    localparam int WARN  = 10;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_timer_if bus();

    game_timer #(
        .START_VALUE   (START),
        .TICKS_PER_UNIT(TPU),
        .WARN_VALUE    (WARN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [11:0] digits;
    assign digits = {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: value, game state and tick count within the current unit
    int m_val   = START;
    int m_state = M_IDLE;
    int m_presc = 0;
    int exp_ct  = 0;
    int exp_tu  = 0;

    // Observation counters, sampled shortly after each rising clock edge
    int cyc = 0, ct_n = 0, tu_n = 0, ct_cyc = -1, d9_cyc = -1, w_cyc = -1;
    bit tu_bad = 1'b0;
    int last_rise = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.count_tick) begin
            ct_n++;
            ct_cyc = cyc;
        end
        if (bus.time_up) begin
            tu_n++;
            if (digits != 12'h000 || !bus.count_tick || bus.running) tu_bad = 1'b1;
        end
        if (d9_cyc < 0 && digits == 12'h009) d9_cyc = cyc;
        if (w_cyc < 0 && bus.warn) w_cyc = cyc;
    end

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic bit m_warn();
        return (m_val < WARN) && (m_state != M_IDLE);
    endfunction

    task automatic m_tick();
        if (m_state == M_RUN) begin
            m_presc++;
            if (m_presc == TPU) begin
                m_presc = 0;
                if (m_val > 0) begin
                    m_val--;
                    exp_ct++;
                    if (m_val == 0) begin
                        m_state = M_EXP;
                        exp_tu++;
                    end
                end
            end
        end
    endtask

    task automatic m_reload();
        m_state = M_IDLE;
        m_val   = START;
        m_presc = 0;
    endtask

    task automatic m_ctrl(input bit s, input bit p, input bit r);
        if (r) m_reload();
        else if (p) begin
            if (m_state == M_RUN) m_state = M_PAUSED;
        end else if (s) begin
            if (m_state == M_IDLE) begin
                m_state = M_RUN;
                m_presc = 0;
            end else if (m_state == M_PAUSED) begin
                m_state = M_RUN;
            end
        end
    endtask

    task automatic drive_tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.tick_in = 1'b1;
            last_rise = cyc;
            m_tick();
            repeat ($urandom_range(2, 5)) @(negedge clk);
            bus.tick_in = 1'b0;
            repeat ($urandom_range(3, 6)) @(negedge clk);
        end
    endtask

    task automatic ctrl(input bit s, input bit p, input bit r);
        @(negedge clk);
        bus.start = s; bus.pause = p; bus.reload = r;
        @(negedge clk);
        bus.start = 1'b0; bus.pause = 1'b0; bus.reload = 1'b0;
        @(negedge clk);
        m_ctrl(s, p, r);
    endtask

    task automatic test_reset();
        bus.tick_in = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.reload = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (digits !== to_bcd(START)) begin n_fail++; $display("FAIL reset_digits: got %h expected %h", digits, to_bcd(START)); end
        n_checks++;
        if ({bus.running, bus.count_tick, bus.warn, bus.time_up} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.running, bus.count_tick, bus.warn, bus.time_up});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.tick_in = 1'b0;
        repeat (4) @(negedge clk);
        drive_tick(10);
        n_checks++;
        if (digits !== to_bcd(m_val)) begin n_fail++; $display("FAIL idle_digits: got %h expected %h", digits, to_bcd(m_val)); end
        n_checks++;
        if (bus.running !== 1'b0 || bus.warn !== 1'b0) begin n_fail++; $display("FAIL idle_flags: got run=%b warn=%b expected 0 0", bus.running, bus.warn); end
        n_checks++;
        if (ct_n !== 0) begin n_fail++; $display("FAIL idle_count_tick: got %0d pulses expected 0", ct_n); end
    endtask

    task automatic test_run_unit();
        int ct0;
        ct0 = ct_n;
        ctrl(1, 0, 0);
        n_checks++;
        if (bus.running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b expected 1", bus.running); end
        drive_tick(3);
        n_checks++;
        if (digits !== 12'h011) begin n_fail++; $display("FAIL unit_digits: got %h expected 011", digits); end
        n_checks++;
        if (ct_n - ct0 !== 1) begin n_fail++; $display("FAIL unit_pulses: got %0d expected 1", ct_n - ct0); end
        n_checks++;
        if (ct_cyc !== last_rise + 3) begin n_fail++; $display("FAIL unit_latency: got cycle %0d expected %0d", ct_cyc, last_rise + 3); end
    endtask

    task automatic test_pause_retain();
        int ct0;
        ct0 = ct_n;
        drive_tick(2);
        ctrl(0, 1, 0);
        drive_tick(5);
        n_checks++;
        if (digits !== to_bcd(m_val) || bus.running !== 1'b0) begin
            n_fail++; $display("FAIL paused_hold: got %h run=%b expected %h run=0", digits, bus.running, to_bcd(m_val));
        end
        ctrl(1, 0, 0);
        drive_tick(1);
        n_checks++;
        if (digits !== 12'h010) begin n_fail++; $display("FAIL resume_digits: got %h expected 010", digits); end
        n_checks++;
        if (ct_n - ct0 !== exp_ct - 1) begin n_fail++; $display("FAIL resume_pulses: got %0d expected %0d", ct_n - ct0, exp_ct - 1); end
    endtask

    task automatic test_warn();
        ctrl(0, 0, 1);
        ctrl(1, 0, 0);
        d9_cyc = -1; w_cyc = -1;
        drive_tick(27);
        n_checks++;
        if (digits !== 12'h003) begin n_fail++; $display("FAIL nine_units: got %h expected 003", digits); end
        n_checks++;
        if (d9_cyc < 0 || w_cyc !== d9_cyc + 1) begin n_fail++; $display("FAIL warn_latency: got cycle %0d expected %0d", w_cyc, d9_cyc + 1); end
        ctrl(0, 1, 0);
        n_checks++;
        if (bus.warn !== m_warn() || bus.running !== 1'b0) begin
            n_fail++; $display("FAIL warn_paused: got warn=%b run=%b expected warn=%b run=0", bus.warn, bus.running, m_warn());
        end
    endtask

    task automatic test_expire();
        int tu0, ct0;
        tu0 = tu_n;
        ctrl(1, 0, 0);
        drive_tick(9);
        n_checks++;
        if (digits !== 12'h000) begin n_fail++; $display("FAIL expire_digits: got %h expected 000", digits); end
        n_checks++;
        if (tu_n - tu0 !== 1 || tu_bad !== 1'b0) begin n_fail++; $display("FAIL time_up_pulse: got %0d cycles bad=%b expected 1 bad=0", tu_n - tu0, tu_bad); end
        n_checks++;
        if (bus.running !== 1'b0) begin n_fail++; $display("FAIL expire_running: got %b expected 0", bus.running); end
        ct0 = ct_n; tu0 = tu_n;
        drive_tick(6);
        ctrl(1, 0, 0);
        ctrl(0, 1, 0);
        drive_tick(3);
        n_checks++;
        if (digits !== 12'h000 || ct_n !== ct0 || tu_n !== tu0 || bus.running !== 1'b0) begin
            n_fail++; $display("FAIL expired_hold: got %h ct=%0d tu=%0d run=%b expected 000 ct=%0d tu=%0d run=0",
                               digits, ct_n, tu_n, bus.running, ct0, tu0);
        end
    endtask

    // Drive one tick and place a control pulse in the cycle its synchronised pulse is live
    task automatic collide_tick(input bit p, input bit r);
        @(negedge clk);
        bus.tick_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.pause = p; bus.reload = r;
        @(negedge clk);
        bus.pause = 1'b0; bus.reload = 1'b0;
        repeat (2) @(negedge clk);
        bus.tick_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_collisions();
        int ct0;
        ctrl(0, 0, 1);
        ctrl(1, 1, 0);
        n_checks++;
        if (bus.running !== 1'b0) begin n_fail++; $display("FAIL start_pause_idle: got %b expected 0", bus.running); end
        ctrl(1, 0, 0);
        drive_tick(2);
        ct0 = ct_n;
        collide_tick(0, 1);
        m_tick();
        m_reload();
        n_checks++;
        if (digits !== to_bcd(START) || bus.running !== 1'b0 || bus.warn !== 1'b0 || ct_n !== ct0) begin
            n_fail++; $display("FAIL reload_vs_tick: got %h run=%b warn=%b ct=%0d expected %h 0 0 %0d",
                               digits, bus.running, bus.warn, ct_n, to_bcd(START), ct0);
        end
        ctrl(1, 0, 0);
        drive_tick(2);
        ct0 = ct_n;
        collide_tick(1, 0);
        m_tick();
        m_ctrl(0, 1, 0);
        n_checks++;
        if (digits !== 12'h011 || bus.running !== 1'b0 || ct_n - ct0 !== 1) begin
            n_fail++; $display("FAIL pause_vs_tick: got %h run=%b pulses=%0d expected 011 0 1", digits, bus.running, ct_n - ct0);
        end
    endtask

    task automatic test_reset_mid_run();
        ctrl(0, 0, 1);
        ctrl(1, 0, 0);
        drive_tick(21);
        n_checks++;
        if (digits !== 12'h005) begin n_fail++; $display("FAIL before_rst: got %h expected 005", digits); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reload();
        n_checks++;
        if (digits !== to_bcd(START) || {bus.running, bus.count_tick, bus.warn, bus.time_up} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_run_reset: got %h flags=%b expected %h flags=0000",
                               digits, {bus.running, bus.count_tick, bus.warn, bus.time_up}, to_bcd(START));
        end
    endtask

    task automatic test_random();
        int ct0, tu0, e_ct0, e_tu0, op;
        ct0 = ct_n; tu0 = tu_n; e_ct0 = exp_ct; e_tu0 = exp_tu;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op < 6)       drive_tick($urandom_range(1, 4));
            else if (op < 8)  ctrl(1, 0, 0);
            else if (op == 8) ctrl(0, 1, 0);
            else              ctrl(0, 0, $urandom_range(0, 3) == 0);
            n_checks++;
            if (digits !== to_bcd(m_val) || bus.running !== (m_state == M_RUN) || bus.warn !== m_warn()) begin
                n_fail++; $display("FAIL random_step%0d: got %h run=%b warn=%b expected %h run=%b warn=%b",
                                   i, digits, bus.running, bus.warn, to_bcd(m_val), m_state == M_RUN, m_warn());
            end
        end
        n_checks++;
        if (ct_n - ct0 !== exp_ct - e_ct0 || tu_n - tu0 !== exp_tu - e_tu0) begin
            n_fail++; $display("FAIL random_pulses: got ct=%0d tu=%0d expected ct=%0d tu=%0d",
                               ct_n - ct0, tu_n - tu0, exp_ct - e_ct0, exp_tu - e_tu0);
        end
    endtask

    initial begin
        test_reset();
        test_run_unit();
        test_pause_retain();
        test_warn();
        test_expire();
        test_collisions();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
